mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - data memory access stage: aligned load/store over a 64-bit handshake data bus
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (bus timeout with mem_o_bus_err reporting)
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] regM_i_valE,
    input  logic [63:0] regM_i_valB,
    input  logic [2:0]  regM_i_load_type,
    input  logic        regM_i_mem_ren,
    input  logic        regM_i_mem_wen,
    input  logic [3:0]  regM_i_mem_wmask,
    output logic        dbus_o_req,
    output logic        dbus_o_we,
    output logic [63:0] dbus_o_addr,
    output logic [63:0] dbus_o_wdata,
    output logic [7:0]  dbus_o_wstrb,
    input  logic        dbus_i_ack,
    input  logic [63:0] dbus_i_rdata,
    output logic [63:0] mem_o_rdata,
    output logic        mem_o_stall,
    output logic        mem_o_misaligned,
    output logic        mem_o_bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        access;
    logic [1:0]  store_size;
    logic [1:0]  size;
    logic        aligned;
    logic        start;
    logic [7:0]  size_mask;
    logic [63:0] wdata_rep;
    logic        timeout;

    logic        we_q;
    logic [2:0]  ld_type_q;
    logic [2:0]  off_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic [63:0] rdata_q;
    logic        err_q;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    // Store width from the byte mask; unknown masks fall back to a doubleword store.
    always_comb begin
        store_size = 2'd3;
        case (regM_i_mem_wmask)
            4'b0001: store_size = 2'd0;
            4'b0011: store_size = 2'd1;
            4'b0111: store_size = 2'd2;
            default: store_size = 2'd3;
        endcase
    end

    // Access width (log2 bytes) and natural-alignment test; load codes 4..7 share widths with 0..3.
    always_comb begin
        access  = regM_i_mem_ren | regM_i_mem_wen;
        size    = regM_i_mem_wen ? store_size : regM_i_load_type[1:0];
        aligned = 1'b1;
        case (size)
            2'd0: aligned = 1'b1;
            2'd1: aligned = ~regM_i_valE[0];
            2'd2: aligned = (regM_i_valE[1:0] == 2'b00);
            default: aligned = (regM_i_valE[2:0] == 3'b000);
        endcase
    end

    // Store data replicated into every lane of its width, and the unshifted lane mask.
    always_comb begin
        wdata_rep = regM_i_valB;
        size_mask = 8'hFF;
        case (size)
            2'd0: begin
                wdata_rep = {8{regM_i_valB[7:0]}};
                size_mask = 8'h01;
            end
            2'd1: begin
                wdata_rep = {4{regM_i_valB[15:0]}};
                size_mask = 8'h03;
            end
            2'd2: begin
                wdata_rep = {2{regM_i_valB[31:0]}};
                size_mask = 8'h0F;
            end
            default: begin
                wdata_rep = regM_i_valB;
                size_mask = 8'hFF;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the combinational stall / misalignment flags.
    always_comb begin
        state_next       = state;
        mem_o_stall      = 1'b0;
        mem_o_misaligned = 1'b0;
        start            = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        mem_o_stall = 1'b1;
                        start       = 1'b1;
                        state_next  = ST_BUSY;
                    end else begin
                        mem_o_misaligned = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                mem_o_stall = 1'b1;
                if (dbus_i_ack || timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Align the returned doubleword to the accessed byte and extend per load code.
    always_comb begin
        shifted  = dbus_i_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (ld_type_q)
            3'd0: load_ext = {{56{shifted[7]}},  shifted[7:0]};
            3'd1: load_ext = {{48{shifted[15]}}, shifted[15:0]};
            3'd2: load_ext = {{32{shifted[31]}}, shifted[31:0]};
            3'd4: load_ext = {56'd0, shifted[7:0]};
            3'd5: load_ext = {48'd0, shifted[15:0]};
            3'd6: load_ext = {32'd0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [3:0] tmo_cnt;

    assign timeout       = (state == ST_BUSY) && !dbus_i_ack && (tmo_cnt == 4'hF);
    assign mem_o_bus_err = err_q;

    // Busy-cycle counter; held at zero outside BUSY so each access starts from a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 4'd0;
        end else if (state == ST_BUSY && !dbus_i_ack) begin
            tmo_cnt <= tmo_cnt + 4'd1;
        end else begin
            tmo_cnt <= 4'd0;
        end
    end
`else
    assign timeout       = 1'b0;
    assign mem_o_bus_err = 1'b0;
`endif

    // Request registers latched at launch and the load result latched when the bus answers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            ld_type_q <= 3'd0;
            off_q     <= 3'd0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            rdata_q   <= 64'd0;
            err_q     <= 1'b0;
        end else begin
            if (start) begin
                we_q      <= regM_i_mem_wen;
                ld_type_q <= regM_i_load_type;
                off_q     <= regM_i_valE[2:0];
                addr_q    <= {regM_i_valE[63:3], 3'b000};
                wdata_q   <= regM_i_mem_wen ? wdata_rep : 64'd0;
                wstrb_q   <= regM_i_mem_wen ? (size_mask << regM_i_valE[2:0]) : 8'd0;
            end
            if (state == ST_BUSY && dbus_i_ack) begin
                rdata_q <= we_q ? 64'd0 : load_ext;
                err_q   <= 1'b0;
            end else if (timeout) begin
                rdata_q <= 64'd0;
                err_q   <= 1'b1;
            end else begin
                err_q   <= 1'b0;
            end
        end
    end

    assign dbus_o_req   = (state == ST_BUSY);
    assign dbus_o_we    = we_q;
    assign dbus_o_addr  = addr_q;
    assign dbus_o_wdata = wdata_q;
    assign dbus_o_wstrb = wstrb_q;
    assign mem_o_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access (directed table, corner sequences, random vs model)
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] regM_i_valE;
    logic [63:0] regM_i_valB;
    logic [2:0]  regM_i_load_type;
    logic        regM_i_mem_ren;
    logic        regM_i_mem_wen;
    logic [3:0]  regM_i_mem_wmask;
    logic        dbus_o_req;
    logic        dbus_o_we;
    logic [63:0] dbus_o_addr;
    logic [63:0] dbus_o_wdata;
    logic [7:0]  dbus_o_wstrb;
    logic        dbus_i_ack;
    logic [63:0] dbus_i_rdata;
    logic [63:0] mem_o_rdata;
    logic        mem_o_stall;
    logic        mem_o_misaligned;
    logic        mem_o_bus_err;

    int total = 0;
    int bad   = 0;

    mem_access dut (
        .clk              (clk),
        .rst              (rst),
        .regM_i_valE      (regM_i_valE),
        .regM_i_valB      (regM_i_valB),
        .regM_i_load_type (regM_i_load_type),
        .regM_i_mem_ren   (regM_i_mem_ren),
        .regM_i_mem_wen   (regM_i_mem_wen),
        .regM_i_mem_wmask (regM_i_mem_wmask),
        .dbus_o_req       (dbus_o_req),
        .dbus_o_we        (dbus_o_we),
        .dbus_o_addr      (dbus_o_addr),
        .dbus_o_wdata     (dbus_o_wdata),
        .dbus_o_wstrb     (dbus_o_wstrb),
        .dbus_i_ack       (dbus_i_ack),
        .dbus_i_rdata     (dbus_i_rdata),
        .mem_o_rdata      (mem_o_rdata),
        .mem_o_stall      (mem_o_stall),
        .mem_o_misaligned (mem_o_misaligned),
        .mem_o_bus_err    (mem_o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ren;
        logic        wen;
        logic [2:0]  lt;
        logic [3:0]  wm;
        logic [63:0] vale;
        logic [63:0] valb;
        logic [63:0] bus;
        int          dly;
        logic        e_mis;
        logic [63:0] e_addr;
        logic [7:0]  e_wstrb;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t tbl[16];
    int   ntbl = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h want 0x%016h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic ren, input logic wen,
                                input logic [2:0] lt, input logic [3:0] wm,
                                input logic [63:0] vale, input logic [63:0] valb,
                                input logic [63:0] bus, input int dly, input logic mis,
                                input logic [63:0] addr, input logic [7:0] wstrb,
                                input logic [63:0] wdata, input logic [63:0] rdata);
        vec_t v;
        v.name = nm; v.ren = ren; v.wen = wen; v.lt = lt; v.wm = wm;
        v.vale = vale; v.valb = valb; v.bus = bus; v.dly = dly;
        v.e_mis = mis; v.e_addr = addr; v.e_wstrb = wstrb; v.e_wdata = wdata; v.e_rdata = rdata;
        return v;
    endfunction

    // Reference: byte-level view of the access, independent of any shift/replicate hardware form.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int n = 8;
        bit sgn = 1'b0;
        int off = int'(v.vale % 8);
        logic [63:0] val = 64'd0;
        if (v.wen) begin
            case (v.wm)
                4'b0001: n = 1;
                4'b0011: n = 2;
                4'b0111: n = 4;
                default: n = 8;
            endcase
        end else begin
            case (v.lt)
                3'd0: begin n = 1; sgn = 1'b1; end
                3'd1: begin n = 2; sgn = 1'b1; end
                3'd2: begin n = 4; sgn = 1'b1; end
                3'd4: n = 1;
                3'd5: n = 2;
                3'd6: n = 4;
                default: n = 8;
            endcase
        end
        r.e_mis  = (off % n) != 0;
        r.e_addr = v.vale - 64'(off);
        r.e_wstrb = 8'(((1 << n) - 1) << off);
        for (int i = 0; i < 8; i++) r.e_wdata[8*i +: 8] = v.valb[8*(i % n) +: 8];
        if (!v.wen && !r.e_mis) begin
            for (int k = 0; k < n; k++) val[8*k +: 8] = v.bus[8*(off + k) +: 8];
            if (sgn && val[8*n - 1]) begin
                for (int k = n; k < 8; k++) val[8*k +: 8] = 8'hFF;
            end
        end
        r.e_rdata = val;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        int stall_cycles;
        @(negedge clk);
        regM_i_mem_ren = v.ren; regM_i_mem_wen = v.wen;
        regM_i_load_type = v.lt; regM_i_mem_wmask = v.wm;
        regM_i_valE = v.vale; regM_i_valB = v.valb;
        dbus_i_rdata = v.bus; dbus_i_ack = 1'b0;
        #1;
        chk({v.name, " misaligned"}, 64'(mem_o_misaligned), 64'(v.e_mis));
        chk({v.name, " idle req"}, 64'(dbus_o_req), 64'd0);
        if (v.e_mis) begin
            chk({v.name, " mis stall"}, 64'(mem_o_stall), 64'd0);
            @(negedge clk);
            regM_i_mem_ren = 1'b0; regM_i_mem_wen = 1'b0;
            #1;
            chk({v.name, " mis no req"}, 64'(dbus_o_req), 64'd0);
            @(negedge clk);
            #1;
            chk({v.name, " mis no req 2"}, 64'(dbus_o_req), 64'd0);
            return;
        end
        chk({v.name, " idle stall"}, 64'(mem_o_stall), 64'd1);
        stall_cycles = 1;
        for (int c = 0; c <= v.dly; c++) begin
            @(negedge clk);
            regM_i_mem_ren = 1'b0; regM_i_mem_wen = 1'b0;
            dbus_i_ack = (c == v.dly);
            #1;
            chk({v.name, " busy req"}, 64'(dbus_o_req), 64'd1);
            chk({v.name, " busy addr"}, dbus_o_addr, v.e_addr);
            chk({v.name, " busy we"}, 64'(dbus_o_we), 64'(v.wen));
            if (v.wen) begin
                chk({v.name, " busy wstrb"}, 64'(dbus_o_wstrb), 64'(v.e_wstrb));
                chk({v.name, " busy wdata"}, dbus_o_wdata, v.e_wdata);
            end
            if (mem_o_stall) stall_cycles++;
        end
        @(negedge clk);
        dbus_i_ack = 1'b1;
        #1;
        chk({v.name, " done req"}, 64'(dbus_o_req), 64'd0);
        chk({v.name, " done stall"}, 64'(mem_o_stall), 64'd0);
        chk({v.name, " done rdata"}, mem_o_rdata, v.e_rdata);
        chk({v.name, " done bus_err"}, 64'(mem_o_bus_err), 64'd0);
        chk({v.name, " stall cycles"}, 64'(stall_cycles), 64'(v.dly + 2));
        @(negedge clk);
        #1;
        chk({v.name, " idle after done"}, 64'(dbus_o_req), 64'd0);
        chk({v.name, " rdata held"}, mem_o_rdata, v.e_rdata);
        dbus_i_ack = 1'b0;
    endtask

    initial begin
        vec_t v;
        int busy;
        rst = 1'b1;
        regM_i_valE = '0; regM_i_valB = '0; regM_i_load_type = '0;
        regM_i_mem_ren = 1'b0; regM_i_mem_wen = 1'b0; regM_i_mem_wmask = '0;
        dbus_i_ack = 1'b0; dbus_i_rdata = '0;

        tbl[ntbl++] = mk("lb_neg",  1, 0, 3'd0, 4'h0, 64'h1003, 64'h0, 64'h00000000_80000000, 0,
                         0, 64'h1000, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80);
        tbl[ntbl++] = mk("sh_hi",   0, 1, 3'd0, 4'b0011, 64'h2006, 64'hABCD, 64'h0, 1,
                         0, 64'h2000, 8'hC0, 64'hABCDABCD_ABCDABCD, 64'h0);
        tbl[ntbl++] = mk("lw_mis",  1, 0, 3'd2, 4'h0, 64'h3002, 64'h0, 64'h0, 0,
                         1, 64'h0, 8'h00, 64'h0, 64'h0);
        tbl[ntbl++] = mk("ld_slow", 1, 0, 3'd3, 4'h0, 64'h4000, 64'h0, 64'h01234567_89ABCDEF, 5,
                         0, 64'h4000, 8'h00, 64'h0, 64'h01234567_89ABCDEF);
        tbl[ntbl++] = mk("lbu",     1, 0, 3'd4, 4'h0, 64'h1003, 64'h0, 64'h00000000_80000000, 0,
                         0, 64'h1000, 8'h00, 64'h0, 64'h80);
        tbl[ntbl++] = mk("lhu",     1, 0, 3'd5, 4'h0, 64'h5006, 64'h0, 64'hBEEF0000_00000000, 2,
                         0, 64'h5000, 8'h00, 64'h0, 64'hBEEF);
        tbl[ntbl++] = mk("lh",      1, 0, 3'd1, 4'h0, 64'h5006, 64'h0, 64'hBEEF0000_00000000, 0,
                         0, 64'h5000, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFBEEF);
        tbl[ntbl++] = mk("lw",      1, 0, 3'd2, 4'h0, 64'h6004, 64'h0, 64'h80000001_00000000, 0,
                         0, 64'h6000, 8'h00, 64'h0, 64'hFFFFFFFF_80000001);
        tbl[ntbl++] = mk("lwu",     1, 0, 3'd6, 4'h0, 64'h6004, 64'h0, 64'h80000001_00000000, 1,
                         0, 64'h6000, 8'h00, 64'h0, 64'h80000001);
        tbl[ntbl++] = mk("sb",      0, 1, 3'd0, 4'b0001, 64'h7005, 64'hFFFF_FF5A, 64'h0, 0,
                         0, 64'h7000, 8'h20, 64'h5A5A5A5A_5A5A5A5A, 64'h0);
        tbl[ntbl++] = mk("sw",      0, 1, 3'd0, 4'b0111, 64'h8004, 64'h9_12345678, 64'h0, 0,
                         0, 64'h8000, 8'hF0, 64'h12345678_12345678, 64'h0);
        tbl[ntbl++] = mk("sd_oddmask", 0, 1, 3'd0, 4'b0101, 64'h9008, 64'h11223344_55667788, 64'h0, 0,
                         0, 64'h9008, 8'hFF, 64'h11223344_55667788, 64'h0);
        tbl[ntbl++] = mk("sh_mis",  0, 1, 3'd0, 4'b0011, 64'h2007, 64'h1, 64'h0, 0,
                         1, 64'h0, 8'h00, 64'h0, 64'h0);
        tbl[ntbl++] = mk("ren_wen", 1, 1, 3'd0, 4'b1111, 64'hA000, 64'hCAFEF00D_12345678, 64'hFF, 0,
                         0, 64'hA000, 8'hFF, 64'hCAFEF00D_12345678, 64'h0);
        tbl[ntbl++] = mk("lt7",     1, 0, 3'd7, 4'h0, 64'hB000, 64'h0, 64'h80000000_00000000, 0,
                         0, 64'hB000, 8'h00, 64'h0, 64'h80000000_00000000);
        tbl[ntbl++] = mk("lt7_mis", 1, 0, 3'd7, 4'h0, 64'hB004, 64'h0, 64'h0, 0,
                         1, 64'h0, 8'h00, 64'h0, 64'h0);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst req", 64'(dbus_o_req), 64'd0);
        chk("rst we", 64'(dbus_o_we), 64'd0);
        chk("rst addr", dbus_o_addr, 64'd0);
        chk("rst wdata", dbus_o_wdata, 64'd0);
        chk("rst wstrb", 64'(dbus_o_wstrb), 64'd0);
        chk("rst rdata", mem_o_rdata, 64'd0);
        chk("rst bus_err", 64'(mem_o_bus_err), 64'd0);
        chk("rst stall", 64'(mem_o_stall), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < ntbl; i++) apply(tbl[i]);

        // Reset in the second BUSY cycle; the following ack lands in IDLE and must be ignored
        apply(mk("ld_pre", 1, 0, 3'd3, 4'h0, 64'hC000, 64'h0, 64'h5555AAAA_12345678, 0,
                 0, 64'hC000, 8'h00, 64'h0, 64'h5555AAAA_12345678));
        @(negedge clk);
        regM_i_mem_ren = 1'b1; regM_i_load_type = 3'd3; regM_i_valE = 64'hD000;
        #1;
        chk("rstbusy launch stall", 64'(mem_o_stall), 64'd1);
        @(negedge clk);
        regM_i_mem_ren = 1'b0;
        #1;
        chk("rstbusy busy1 req", 64'(dbus_o_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstbusy busy2 req", 64'(dbus_o_req), 64'd1);
        @(negedge clk);
        rst = 1'b0; dbus_i_ack = 1'b1;
        #1;
        chk("rstbusy req dropped", 64'(dbus_o_req), 64'd0);
        chk("rstbusy rdata", mem_o_rdata, 64'd0);
        chk("rstbusy addr", dbus_o_addr, 64'd0);
        chk("rstbusy stall", 64'(mem_o_stall), 64'd0);
        @(negedge clk);
        dbus_i_ack = 1'b0;
        #1;
        chk("rstbusy late ack ignored", 64'(dbus_o_req), 64'd0);
        chk("rstbusy rdata stays", mem_o_rdata, 64'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No ack at all: 16 BUSY cycles, then a DONE cycle flagged as a bus error
        apply(mk("ld_pre2", 1, 0, 3'd3, 4'h0, 64'hE000, 64'h0, 64'h0F0F0F0F_0F0F0F0F, 0,
                 0, 64'hE000, 8'h00, 64'h0, 64'h0F0F0F0F_0F0F0F0F));
        @(negedge clk);
        regM_i_mem_ren = 1'b1; regM_i_load_type = 3'd3; regM_i_valE = 64'hE008;
        busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            regM_i_mem_ren = 1'b0;
            #1;
            if (!dbus_o_req) break;
            busy++;
        end
        chk("timeout busy cycles", 64'(busy), 64'd16);
        chk("timeout bus_err", 64'(mem_o_bus_err), 64'd1);
        chk("timeout rdata", mem_o_rdata, 64'd0);
        chk("timeout stall", 64'(mem_o_stall), 64'd0);
        @(negedge clk);
        #1;
        chk("timeout err one cycle", 64'(mem_o_bus_err), 64'd0);
        chk("timeout idle req", 64'(dbus_o_req), 64'd0);
`else
        // Without the timeout the bus may answer arbitrarily late
        apply(mk("ld_very_slow", 1, 0, 3'd1, 4'h0, 64'hE002, 64'h0, 64'h00000000_7FFF0000, 20,
                 0, 64'hE000, 8'h00, 64'h0, 64'h7FFF));
`endif

        for (int i = 0; i < 60; i++) begin
            logic [3:0] masks [5];
            logic [1:0] k;
            masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b0111; masks[3] = 4'b1111;
            masks[4] = 4'($urandom);
            k = 2'($urandom);
            v.name = "rand";
            v.ren  = 1'($urandom);
            v.wen  = 1'($urandom);
            if (!v.ren && !v.wen) v.ren = 1'b1;
            v.lt   = 3'($urandom);
            v.wm   = masks[$urandom_range(0, 4)];
            v.vale = {$urandom, $urandom};
            if (k != 2'd0) v.vale[2:0] = 3'($urandom_range(0, 1)) << ($urandom_range(0, 2));
            v.valb = {$urandom, $urandom};
            v.bus  = {$urandom, $urandom};
            v.dly  = $urandom_range(0, 3);
            apply(model(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
